uart_tx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_fifo_sync_fifo.sv | 62 ++++++
 rtl/uart_tx_fifo.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, shifter states and the baud divisor.
package uart_pkg;

    // Parity mode selectors for the PARITY parameter.
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Transmit shifter states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } txState_t;

    // Clocks per bit cell, rounded to the nearest integer.
    function automatic int baud_div(input int clkFreq, input int baud);
        return (clkFreq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with show-ahead read data and an occupancy counter.
// The read port is combinational so the shifter can load a word on the pop edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wrData,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdData,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtrReg;
    logic [PTR_W-1:0] rdPtrReg;
    logic [PTR_W:0]   countReg;
    logic             doPush;
    logic             doPop;

    // Requests against a full or empty FIFO are dropped here.
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign full   = (countReg == (PTR_W + 1)'(DEPTH));
    assign empty  = (countReg == '0);
    assign count  = countReg;
    assign rdData = mem[rdPtrReg];

    // Storage array; left without reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtrReg] <= wrData;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
        end else begin
            if (doPush) begin
                wrPtrReg <= wrPtrReg + PTR_W'(1);
            end
            if (doPop) begin
                rdPtrReg <= rdPtrReg + PTR_W'(1);
            end
            if (doPush && !doPop) begin
                countReg <= countReg + (PTR_W + 1)'(1);
            end else if (doPop && !doPush) begin
                countReg <= countReg - (PTR_W + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter fed by an internal FIFO. Queued characters
// leave back-to-back: the next start bit follows the last stop cell directly.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 19200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tx_valid,
    input  logic [DATA_BITS-1:0]        tx_data,
    output logic                        tx_ready,
    output logic                        txd,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int DIV      = baud_div(CLK_FREQ, BAUD);
    localparam int STOP_LEN = STOP_BITS * DIV;
    localparam int CNT_W    = $clog2(STOP_LEN + 1);
    localparam int BIT_W    = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CELL_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_LEN - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

    txState_t               stateReg, stateNext;
    logic [CNT_W-1:0]       cntReg, cntNext;
    logic [BIT_W-1:0]       bitIdxReg, bitIdxNext;
    logic [DATA_BITS-1:0]   shiftReg, shiftNext;
    logic                   parityReg, parityNext;
    logic                   txdReg, txdNext;

    logic                   fifoPop;
    logic                   fifoFull;
    logic                   fifoEmpty;
    logic [DATA_BITS-1:0]   fifoRdData;
    logic                   loadParity;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) txFifo (
        .clk    (clk),
        .rst    (rst),
        .push   (tx_valid),
        .wrData (tx_data),
        .pop    (fifoPop),
        .rdData (fifoRdData),
        .full   (fifoFull),
        .empty  (fifoEmpty),
        .count  (fifo_count)
    );

    // Parity bit for the word at the FIFO head, used when a frame is loaded.
    assign loadParity = (PARITY == PAR_ODD) ? ~(^fifoRdData) : (^fifoRdData);

    assign tx_ready = !fifoFull;
    assign txd      = txdReg;
    assign busy     = (stateReg != ST_IDLE) || !fifoEmpty;

    // Shifter registers; reset forces the line idle-high immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg  <= ST_IDLE;
            cntReg    <= '0;
            bitIdxReg <= '0;
            shiftReg  <= '0;
            parityReg <= 1'b0;
            txdReg    <= 1'b1;
        end else begin
            stateReg  <= stateNext;
            cntReg    <= cntNext;
            bitIdxReg <= bitIdxNext;
            shiftReg  <= shiftNext;
            parityReg <= parityNext;
            txdReg    <= txdNext;
        end
    end

    // Next-state logic: each cell lasts DIV clocks, the stop period STOP_LEN.
    always_comb begin
        stateNext  = stateReg;
        cntNext    = cntReg + CNT_W'(1);
        bitIdxNext = bitIdxReg;
        shiftNext  = shiftReg;
        parityNext = parityReg;
        txdNext    = txdReg;
        fifoPop    = 1'b0;

        case (stateReg)
            ST_IDLE: begin
                cntNext = '0;
                txdNext = 1'b1;
                if (!fifoEmpty) begin
                    fifoPop    = 1'b1;
                    shiftNext  = fifoRdData;
                    parityNext = loadParity;
                    txdNext    = 1'b0;
                    stateNext  = ST_START;
                end
            end

            ST_START: begin
                if (cntReg == CELL_LAST) begin
                    cntNext    = '0;
                    bitIdxNext = '0;
                    txdNext    = shiftReg[0];
                    shiftNext  = shiftReg >> 1;
                    stateNext  = ST_DATA;
                end
            end

            ST_DATA: begin
                if (cntReg == CELL_LAST) begin
                    cntNext = '0;
                    if (bitIdxReg == BIT_LAST) begin
                        if (PARITY != PAR_NONE) begin
                            txdNext   = parityReg;
                            stateNext = ST_PARITY;
                        end else begin
                            txdNext   = 1'b1;
                            stateNext = ST_STOP;
                        end
                    end else begin
                        bitIdxNext = bitIdxReg + BIT_W'(1);
                        txdNext    = shiftReg[0];
                        shiftNext  = shiftReg >> 1;
                    end
                end
            end

            ST_PARITY: begin
                if (cntReg == CELL_LAST) begin
                    cntNext   = '0;
                    txdNext   = 1'b1;
                    stateNext = ST_STOP;
                end
            end

            ST_STOP: begin
                if (cntReg == STOP_LAST) begin
                    cntNext = '0;
                    if (!fifoEmpty) begin
                        // Chain straight into the next frame with no idle cell.
                        fifoPop    = 1'b1;
                        shiftNext  = fifoRdData;
                        parityNext = loadParity;
                        txdNext    = 1'b0;
                        stateNext  = ST_START;
                    end else begin
                        stateNext = ST_IDLE;
                    end
                end
            end

            default: begin
                cntNext   = '0;
                txdNext   = 1'b1;
                stateNext = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four instances (8N1, 8O1, 8E1, 7E2) at DIV=10.
module tb_uart_tx_fifo;
    localparam int DIV = 10;

    logic             clk;
    logic             rst;
    logic [3:0]       validV;
    logic [3:0][8:0]  dataV;
    logic [3:0]       readyV;
    logic [3:0]       txdV;
    logic [3:0]       busyV;
    logic [3:0][4:0]  countV;

    int checks = 0;
    int errors = 0;

    uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u8n1 (
        .clk(clk), .rst(rst), .tx_valid(validV[0]), .tx_data(dataV[0][7:0]), .tx_ready(readyV[0]),
        .txd(txdV[0]), .busy(busyV[0]), .fifo_count(countV[0]));
    uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u8o1 (
        .clk(clk), .rst(rst), .tx_valid(validV[1]), .tx_data(dataV[1][7:0]), .tx_ready(readyV[1]),
        .txd(txdV[1]), .busy(busyV[1]), .fifo_count(countV[1]));
    uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u8e1 (
        .clk(clk), .rst(rst), .tx_valid(validV[2]), .tx_data(dataV[2][7:0]), .tx_ready(readyV[2]),
        .txd(txdV[2]), .busy(busyV[2]), .fifo_count(countV[2]));
    uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16)) u7e2 (
        .clk(clk), .rst(rst), .tx_valid(validV[3]), .tx_data(dataV[3][6:0]), .tx_ready(readyV[3]),
        .txd(txdV[3]), .busy(busyV[3]), .fifo_count(countV[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net in case the sequence below ever stalls.
    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input int inst, input logic [8:0] d);
        validV[inst] = 1'b1;
        dataV[inst]  = d;
        tick();
        validV[inst] = 1'b0;
    endtask

    // Walks a frame clock by clock; cells[i] is the level of bit cell i.
    // Entered at sample index 'first' of the frame, leaves one clock past its end.
    task automatic expect_frame(input int inst, input logic [15:0] cells, input int ncells,
                                input int first, input string tag);
        int   bad = 0;
        logic lastBusy = 1'b0;
        for (int t = first; t < ncells * DIV; t++) begin
            if (txdV[inst] !== cells[t / DIV]) bad++;
            lastBusy = busyV[inst];
            tick();
        end
        check({tag, " txd bad clocks"}, bad, 0);
        check({tag, " busy on last clock"}, {31'd0, lastBusy}, 1);
    endtask

    function automatic logic [15:0] cells8n1(input logic [7:0] d);
        return {6'b0, 1'b1, d, 1'b0};
    endfunction

    initial begin
        int          accepts;
        int          bad;
        logic        acc;
        logic [7:0]  d;

        rst    = 1'b0;
        validV = '0;
        dataV  = '0;
        #2 rst = 1'b1;
        tick(); tick(); tick();

        // Reset state
        check("reset txd",        {31'd0, txdV[0]},   1);
        check("reset tx_ready",   {31'd0, readyV[0]}, 1);
        check("reset busy",       {31'd0, busyV[0]},  0);
        check("reset fifo_count", {27'd0, countV[0]}, 0);
        check("reset txd 7E2",    {31'd0, txdV[3]},   1);
        rst = 1'b0;
        tick(); tick();

        // 8N1 single frame 0xA5: 0,1,0,1,0,0,1,0,1,1
        push(0, 9'h0A5);
        check("8N1 count after push", {27'd0, countV[0]}, 1);
        check("8N1 txd before pop",   {31'd0, txdV[0]},   1);
        check("8N1 busy after push",  {31'd0, busyV[0]},  1);
        tick();
        check("8N1 count after pop",  {27'd0, countV[0]}, 0);
        expect_frame(0, 16'h034A, 10, 0, "8N1 A5");
        check("8N1 busy after frame", {31'd0, busyV[0]}, 0);
        check("8N1 txd idle",         {31'd0, txdV[0]},  1);

        // Odd parity 0xA5 -> parity cell 1, 110 clocks
        push(1, 9'h0A5);
        tick();
        expect_frame(1, 16'h074A, 11, 0, "8O1 A5");
        check("8O1 busy after frame", {31'd0, busyV[1]}, 0);

        // Even parity 0xA5 -> parity cell 0
        push(2, 9'h0A5);
        tick();
        expect_frame(2, 16'h054A, 11, 0, "8E1 A5");
        check("8E1 busy after frame", {31'd0, busyV[2]}, 0);

        // 7E2 0x41: start, 1,0,0,0,0,0,1, parity 0, two stops
        push(3, 9'h041);
        tick();
        expect_frame(3, 16'h0682, 11, 0, "7E2 41");
        check("7E2 busy after frame", {31'd0, busyV[3]}, 0);

        // Back-to-back 0x00, 0xFF, 0x55 pushed on consecutive cycles
        validV[0] = 1'b1; dataV[0] = 9'h000;
        tick();
        dataV[0] = 9'h0FF;
        tick();
        check("b2b first start txd", {31'd0, txdV[0]}, 0);
        dataV[0] = 9'h055;
        tick();
        validV[0] = 1'b0;
        check("b2b count during f1", {27'd0, countV[0]}, 2);
        expect_frame(0, 16'h0200, 10, 1, "b2b 00");
        check("b2b count at f2", {27'd0, countV[0]}, 1);
        expect_frame(0, 16'h03FE, 10, 0, "b2b FF");
        check("b2b count at f3", {27'd0, countV[0]}, 0);
        expect_frame(0, 16'h02AA, 10, 0, "b2b 55");
        check("b2b busy after", {31'd0, busyV[0]}, 0);

        // Full: hold valid 20 cycles, data advances on each accept
        accepts = 0;
        d = 8'h10;
        for (int i = 0; i < 20; i++) begin
            validV[0] = 1'b1;
            dataV[0]  = {1'b0, d};
            acc = readyV[0];
            tick();
            if (acc) begin
                accepts++;
                d = d + 8'd1;
            end
        end
        validV[0] = 1'b0;
        check("full accepts",  accepts, 17);
        check("full count",    {27'd0, countV[0]}, 16);
        check("full tx_ready", {31'd0, readyV[0]}, 0);
        expect_frame(0, cells8n1(8'h10), 10, 18, "full w10");
        check("full ready after pop", {31'd0, readyV[0]}, 1);
        for (int w = 1; w <= 16; w++) begin
            check($sformatf("full count at w%0d", w), {27'd0, countV[0]}, 32'(16 - w));
            expect_frame(0, cells8n1(8'(8'h10 + w)), 10, 0, $sformatf("full w%0h", 8'h10 + w));
        end
        check("full drained busy",  {31'd0, busyV[0]},  0);
        check("full drained count", {27'd0, countV[0]}, 0);

        // Reset mid-frame at clock 35 with three words queued
        validV[0] = 1'b1; dataV[0] = 9'h000;
        tick();
        dataV[0] = 9'h0FF; tick();
        dataV[0] = 9'h055; tick();
        dataV[0] = 9'h0A5; tick();
        validV[0] = 1'b0;
        for (int i = 0; i < 33; i++) tick();
        check("midrst count before", {27'd0, countV[0]}, 3);
        check("midrst txd before",   {31'd0, txdV[0]},   0);
        #2 rst = 1'b1;
        #1;
        check("midrst txd async",   {31'd0, txdV[0]},   1);
        check("midrst count",       {27'd0, countV[0]}, 0);
        check("midrst busy",        {31'd0, busyV[0]},  0);
        check("midrst tx_ready",    {31'd0, readyV[0]}, 1);
        tick();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 150; i++) begin
            if (txdV[0] !== 1'b1 || busyV[0] !== 1'b0) bad++;
            tick();
        end
        check("midrst quiet after release", bad, 0);

        // Recovery with a fresh push
        push(0, 9'h0A5);
        tick();
        expect_frame(0, 16'h034A, 10, 0, "recover A5");
        check("recover busy", {31'd0, busyV[0]}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
